// File: rtl/load_store_unit.sv
// Load/store execution unit: accepts one memory op at a time from the dispatch
// port, sequences it byte by byte over a synchronous byte-wide RAM
// (little-endian, address wraps at ADDR_WIDTH), and broadcasts the tag plus the
// result on the result bus for a single cycle.
module load_store_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int TAG_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [5:0]            memory_op,
   input  logic [31:0]           memory_value1,
   input  logic [31:0]           memory_value2,
   input  logic [TAG_WIDTH-1:0]  memory_des,
   output logic                  memory_busy,
   output logic [31:0]           memory_data,
   output logic [TAG_WIDTH-1:0]  memory_des_in,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic [7:0]            mem_dout,
   output logic                  mem_wr,
   input  logic [7:0]            mem_din
);

   localparam logic [5:0] OP_LB  = 6'd18;
   localparam logic [5:0] OP_LH  = 6'd19;
   localparam logic [5:0] OP_LW  = 6'd20;
   localparam logic [5:0] OP_LBU = 6'd21;
   localparam logic [5:0] OP_LHU = 6'd22;
   localparam logic [5:0] OP_SB  = 6'd23;
   localparam logic [5:0] OP_SH  = 6'd24;
   localparam logic [5:0] OP_SW  = 6'd25;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DRAIN
   } state_t;

   state_t                state;
   state_t                state_next;

   logic [5:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [TAG_WIDTH-1:0]  tag_q;

   logic [1:0]            idx;        // byte currently on the RAM address bus
   logic [1:0]            idx_next;
   logic [1:0]            last_idx;   // n-1 for the latched op
   logic                  is_store;
   logic                  accept;

   logic                  rd_valid;   // a read address was presented last cycle
   logic [1:0]            rd_idx;     // which result byte that read fills
   logic [31:0]           rdata_q;
   logic [31:0]           load_word;
   logic [31:0]           load_result;

   assign accept   = (state == IDLE) && !memory_busy && (memory_des != '0) &&
                     (memory_op >= OP_LB) && (memory_op <= OP_SW);
   assign is_store = (op_q >= OP_SB);
   assign idx_next = idx + 2'd1;

   // Last byte index of the latched op, from its access size.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      last_idx = 2'd0;
      case (op_q)
         OP_LH, OP_LHU, OP_SH: last_idx = 2'd1;
         OP_LW, OP_SW:         last_idx = 2'd3;
         default:              last_idx = 2'd0;
      endcase
   end

   // Assemble the final load word (last byte arrives in the DRAIN cycle) and extend it.
   always_comb begin
      load_word = rdata_q;
      if (rd_valid) begin
         load_word[{rd_idx, 3'b000} +: 8] = mem_din;
      end
      load_result = load_word;
      case (op_q)
         OP_LB:   load_result = {{24{load_word[7]}}, load_word[7:0]};
         OP_LH:   load_result = {{16{load_word[15]}}, load_word[15:0]};
         OP_LBU:  load_result = {24'h0, load_word[7:0]};
         OP_LHU:  load_result = {16'h0, load_word[15:0]};
         default: load_result = load_word;
      endcase
   end

   // Next-state logic: IDLE -> ACCESS -> (loads only) DRAIN -> IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) state_next = ACCESS;
         end
         ACCESS: begin
            if (idx == last_idx) state_next = is_store ? IDLE : DRAIN;
         end
         DRAIN: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath: latch the request, walk the byte addresses, capture load bytes, broadcast.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q          <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         tag_q         <= '0;
         idx           <= '0;
         rd_valid      <= 1'b0;
         rd_idx        <= '0;
         rdata_q       <= '0;
         memory_busy   <= 1'b0;
         memory_data   <= '0;
         memory_des_in <= '0;
         mem_a         <= '0;
         mem_dout      <= '0;
         mem_wr        <= 1'b0;
      end else begin
         // NOTE: non-blocking here so every register is computed from pre-edge values.
         memory_des_in <= '0;
         rd_valid      <= 1'b0;
         if (rd_valid) begin
            rdata_q[{rd_idx, 3'b000} +: 8] <= mem_din;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q        <= memory_op;
                  addr_q      <= memory_value1[ADDR_WIDTH-1:0];
                  wdata_q     <= memory_value2;
                  tag_q       <= memory_des;
                  idx         <= 2'd0;
                  rdata_q     <= '0;
                  memory_busy <= 1'b1;
                  mem_a       <= memory_value1[ADDR_WIDTH-1:0];
                  mem_dout    <= memory_value2[7:0];
                  mem_wr      <= (memory_op >= OP_SB);
               end
            end
            ACCESS: begin
               if (!is_store) begin
                  // The address presented this cycle returns data one cycle later.
                  rd_valid <= 1'b1;
                  rd_idx   <= idx;
               end
               if (idx == last_idx) begin
                  if (is_store) begin
                     mem_wr        <= 1'b0;
                     memory_des_in <= tag_q;
                     memory_data   <= '0;
                     memory_busy   <= 1'b0;
                  end
               end else begin
                  idx      <= idx_next;
                  mem_a    <= addr_q + ADDR_WIDTH'(idx_next);
                  mem_dout <= wdata_q[{idx_next, 3'b000} +: 8];
               end
            end
            DRAIN: begin
               memory_data   <= load_result;
               memory_des_in <= tag_q;
               memory_busy   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array memory model computes the
// expected write stream and broadcasts when each op is issued; a negedge monitor
// compares them against the DUT as they appear.
module tb_load_store_unit;

   localparam int AW = 32;
   localparam int TW = 3;

   localparam logic [5:0] LB  = 6'd18;
   localparam logic [5:0] LH  = 6'd19;
   localparam logic [5:0] LW  = 6'd20;
   localparam logic [5:0] LBU = 6'd21;
   localparam logic [5:0] LHU = 6'd22;
   localparam logic [5:0] SB  = 6'd23;
   localparam logic [5:0] SH  = 6'd24;
   localparam logic [5:0] SW  = 6'd25;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [5:0]    memory_op;
   logic [31:0]   memory_value1;
   logic [31:0]   memory_value2;
   logic [TW-1:0] memory_des;
   logic          memory_busy;
   logic [31:0]   memory_data;
   logic [TW-1:0] memory_des_in;
   logic [AW-1:0] mem_a;
   logic [7:0]    mem_dout;
   logic          mem_wr;
   logic [7:0]    mem_din;

   load_store_unit #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .memory_op     (memory_op),
      .memory_value1 (memory_value1),
      .memory_value2 (memory_value2),
      .memory_des    (memory_des),
      .memory_busy   (memory_busy),
      .memory_data   (memory_data),
      .memory_des_in (memory_des_in),
      .mem_a         (mem_a),
      .mem_dout      (mem_dout),
      .mem_wr        (mem_wr),
      .mem_din       (mem_din)
   );

   always #5 clk = ~clk;

   // Edge counter: read after an edge it equals the index of that edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      logic [2:0]  tag;
      logic [31:0] data;
   } bc_t;

   typedef struct {
      int          at;
      logic [31:0] addr;
      logic [7:0]  b;
   } wr_t;

   bc_t        bq[$];
   wr_t        wq[$];
   logic [7:0] gmem [0:255];   // reference memory contents (low 8 address bits)
   logic [7:0] ram  [0:255];   // RAM the DUT talks to
   int         total = 0;
   int         bad = 0;
   int         m_accept_edge = 0;
   int         m_done_edge = 0;
   bit         started = 1'b0;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 29 + 7) ^ (i >> 3));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Synchronous byte RAM: read data appears one cycle after the address.
   initial begin
      for (int i = 0; i < 256; i++) ram[i] = init_byte(i);
      forever begin
         @(posedge clk);
         mem_din <= ram[mem_a[7:0]];
         if (mem_wr) ram[mem_a[7:0]] = mem_dout;
      end
   end

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [5:0] op);
      case (op)
         LB, LBU, SB: return 1;
         LH, LHU, SH: return 2;
         default:     return 4;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] w);
      case (op)
         LB:      return 32'($signed(w[7:0]));
         LH:      return 32'($signed(w[15:0]));
         LBU:     return {24'h0, w[7:0]};
         LHU:     return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Record what an op accepted at edge t0 must do.
   task automatic model_issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] tag, input int t0);
      int          n;
      logic [31:0] w;
      logic [31:0] ai;
      bc_t         be;
      wr_t         we;
      n = nbytes(op);
      w = 32'h0;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         if (op >= SB) begin
            we.at   = t0 + i;
            we.addr = ai;
            we.b    = d[8*i +: 8];
            wq.push_back(we);
            gmem[ai[7:0]] = d[8*i +: 8];
         end else begin
            w[8*i +: 8] = gmem[ai[7:0]];
         end
      end
      be.tag = tag;
      if (op >= SB) begin
         be.at       = t0 + n;
         be.data     = 32'h0;
         m_done_edge = t0 + n;
      end else begin
         be.at       = t0 + n + 1;
         be.data     = extend(op, w);
         m_done_edge = t0 + n + 1;
      end
      bq.push_back(be);
      m_accept_edge = t0;
   endtask

   // ---------------- stimulus helpers ----------------
   // Present a valid request and hold it until the unit is free to take it.
   task automatic dispatch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] tag);
      @(negedge clk);
      memory_op     = op;
      memory_value1 = a;
      memory_value2 = d;
      memory_des    = tag;
      @(posedge clk); #1;
      while (cyc <= m_done_edge) begin
         @(posedge clk); #1;
      end
      model_issue(op, a, d, tag, cyc);
   endtask

   // Present a request for exactly one edge; it must not be accepted.
   task automatic poke(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] tag);
      @(negedge clk);
      memory_op     = op;
      memory_value1 = a;
      memory_value2 = d;
      memory_des    = tag;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      memory_des = '0;
      memory_op  = 6'd0;
      repeat (n) @(negedge clk);
   endtask

   // Abort an op with an asynchronous reset two edges after it was accepted.
   task automatic reset_mid(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] tag);
      logic [31:0] a2;
      logic [31:0] a3;
      logic [7:0]  old2;
      logic [7:0]  old3;
      a2   = a + 32'd2;
      a3   = a + 32'd3;
      old2 = gmem[a2[7:0]];
      old3 = gmem[a3[7:0]];
      dispatch(op, a, d, tag);
      @(negedge clk);
      memory_des = '0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(memory_busy), 32'd0);
      check("rst_mid_wr", 32'(mem_wr), 32'd0);
      check("rst_mid_des_in", 32'(memory_des_in), 32'd0);
      check("rst_mid_data", memory_data, 32'd0);
      bq.delete();
      wq.delete();
      // Only the first two bytes of an aborted word store reach the RAM.
      if (op >= SB) begin
         gmem[a2[7:0]] = old2;
         gmem[a3[7:0]] = old3;
      end
      m_done_edge = cyc;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   // ---------------- monitor ----------------
   bc_t mb;
   wr_t mw;
   always @(negedge clk) begin
      if (rst_n && started) begin
         check("busy", 32'(memory_busy), 32'(cyc >= m_accept_edge && cyc < m_done_edge));

         if (memory_des_in != '0) begin
            if (bq.size() == 0) begin
               check("bcast_unexpected", 32'(memory_des_in), 32'd0);
            end else begin
               mb = bq.pop_front();
               check("bcast_tag", 32'(memory_des_in), 32'(mb.tag));
               check("bcast_data", memory_data, mb.data);
               check("bcast_edge", cyc, mb.at);
            end
         end else if (bq.size() != 0 && bq[0].at <= cyc) begin
            mb = bq.pop_front();
            check("bcast_missing", 32'(memory_des_in), 32'(mb.tag));
         end

         if (mem_wr) begin
            if (wq.size() == 0) begin
               check("write_unexpected", 32'(mem_wr), 32'd0);
            end else begin
               mw = wq.pop_front();
               check("write_addr", mem_a, mw.addr);
               check("write_byte", 32'(mem_dout), 32'(mw.b));
               check("write_edge", cyc, mw.at);
            end
         end else if (wq.size() != 0 && wq[0].at <= cyc) begin
            mw = wq.pop_front();
            check("write_missing", 32'(mem_wr), 32'd1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before 500us");
      $fatal(1, "watchdog expired");
   end

   // ---------------- test sequence ----------------
   initial begin
      int r;
      memory_op     = 6'd0;
      memory_value1 = 32'h0;
      memory_value2 = 32'h0;
      memory_des    = '0;
      for (int i = 0; i < 256; i++) gmem[i] = init_byte(i);

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(memory_busy), 32'd0);
      check("rst_des_in", 32'(memory_des_in), 32'd0);
      check("rst_data", memory_data, 32'd0);
      check("rst_wr", 32'(mem_wr), 32'd0);
      check("rst_a", mem_a, 32'd0);
      check("rst_dout", 32'(mem_dout), 32'd0);
      #2 rst_n = 1'b1;
      m_done_edge = cyc;
      started = 1'b1;

      // Reset aborting a load and a store in flight.
      reset_mid(LW, 32'h0000_0040, 32'h0, 3'd1);
      idle(4);
      reset_mid(SW, 32'h0000_0060, 32'h1122_3344, 3'd2);
      idle(4);

      // Word store, word load back, then extension cases.
      dispatch(SW, 32'h0000_0100, 32'hA1B2_C3D4, 3'd3);
      idle(2);
      dispatch(LW, 32'h0000_0100, 32'h0, 3'd5);
      idle(2);
      dispatch(LB, 32'h0000_0102, 32'h0, 3'd6);
      idle(1);
      dispatch(LBU, 32'h0000_0102, 32'h0, 3'd7);
      idle(1);
      dispatch(LH, 32'h0000_0102, 32'h0, 3'd1);
      idle(1);
      dispatch(LHU, 32'h0000_0102, 32'h0, 3'd2);
      idle(1);

      // Back-to-back: second request held on the bus until busy falls.
      dispatch(SB, 32'h0000_0180, 32'h0000_00C5, 3'd4);
      dispatch(LB, 32'h0000_0180, 32'h0, 3'd6);
      dispatch(LH, 32'h0000_017F, 32'h0, 3'd2);
      idle(3);

      // Ignored requests while idle.
      poke(LW, 32'h0000_0100, 32'h0, 3'd0);
      check("ign_tag0_busy", 32'(memory_busy), 32'd0);
      poke(6'd0, 32'h0000_0100, 32'h0, 3'd2);
      check("ign_add_busy", 32'(memory_busy), 32'd0);
      poke(6'd26, 32'h0000_0100, 32'h0, 3'd3);
      check("ign_op26_busy", 32'(memory_busy), 32'd0);
      poke(6'd17, 32'h0000_0100, 32'h0, 3'd1);
      check("ign_op17_busy", 32'(memory_busy), 32'd0);
      idle(2);

      // A one-cycle store request while a load is busy must leave no trace.
      dispatch(LW, 32'h0000_0104, 32'h0, 3'd1);
      poke(SB, 32'h0000_0104, 32'h0000_00FF, 3'd7);
      idle(6);

      // Address wrap-around at the top of the address space.
      dispatch(SW, 32'hFFFF_FFFE, 32'hCAFE_F00D, 3'd3);
      idle(1);
      dispatch(LW, 32'hFFFF_FFFE, 32'h0, 3'd4);
      idle(1);

      // Randomized mix of valid ops, gaps and junk requests.
      for (int k = 0; k < 150; k++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            if ($urandom_range(0, 1) == 1)
               poke(6'($urandom_range(26, 63)), $urandom, $urandom, 3'($urandom_range(1, 7)));
            else
               poke(6'($urandom_range(0, 17)), $urandom, $urandom, 3'($urandom_range(1, 7)));
         end else if (r == 1) begin
            poke(6'(18 + $urandom_range(0, 7)), $urandom, $urandom, 3'd0);
         end else begin
            dispatch(6'(18 + $urandom_range(0, 7)), $urandom, $urandom, 3'($urandom_range(1, 7)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 3)));
         end
      end
      idle(12);

      check("bcast_queue_drained", 32'(bq.size()), 32'd0);
      check("write_queue_drained", 32'(wq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
